// File: rtl/link_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | link_frame_scheduler: packs trace words and SWD responses into frames.    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module link_frame_scheduler #(
  parameter int FRAME_WORDS  = 8,
  parameter int FLUSH_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  width,
  input  logic        sync,
  input  logic        tr_valid,
  input  logic [15:0] tr_word,
  input  logic [4:0]  tr_level,
  output logic        tr_ready,
  input  logic        swd_valid,
  input  logic [31:0] swd_data,
  input  logic        swd_parity,
  output logic        swd_ready,
  output logic        out_valid,
  output logic [15:0] out_word,
  input  logic        out_ready,
  output logic        busy,
  output logic [5:0]  seq
);

  localparam int FCW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [4:0]     TOTAL_W   = 5'(FRAME_WORDS + 1);
  localparam logic [4:0]     FW5       = 5'(FRAME_WORDS);
  localparam logic [FCW-1:0] FLUSH_MAX = FCW'(FLUSH_CYCLES);

  typedef enum logic [2:0] {
    ARB       = 3'd0,
    HDR       = 3'd1,
    TRACE_PAY = 3'd2,
    SWD_PAY   = 3'd3,
    PAD       = 3'd4
  } state_t;

  state_t         state;
  logic           last_grant_swd;
  logic [FCW-1:0] flush_cnt;
  logic [3:0]     remaining;
  logic [4:0]     loaded;
  logic [15:0]    swd_lo;
  logic [15:0]    swd_hi;

  logic        load_en;
  logic        trace_due;
  logic        grant_swd;
  logic        grant_trace;
  logic [3:0]  trace_cnt;
  logic [3:0]  hdr_cnt;
  logic [5:0]  seq_next;
  logic [15:0] header;
  logic        last_loaded;

  assign load_en     = !out_valid || out_ready;
  assign trace_due   = (tr_level >= FW5) || ((tr_level != 5'd0) && (flush_cnt == FLUSH_MAX));
  // When both sources wait, the one not served last time wins.
  assign grant_swd   = swd_valid && (!trace_due || !last_grant_swd);
  assign grant_trace = trace_due && (!swd_valid || last_grant_swd);
  assign trace_cnt   = (tr_level >= FW5) ? FW5[3:0] : tr_level[3:0];
  assign hdr_cnt     = grant_swd ? 4'd2 : (grant_trace ? trace_cnt : 4'd0);
  assign seq_next    = seq + 6'd1;
  assign header      = {grant_swd || grant_trace, grant_swd, width, sync, hdr_cnt,
                        grant_swd ? swd_parity : 1'b0, seq_next};
  // True when the word being loaded now is the last word of the frame.
  assign last_loaded = (loaded == FW5);
  assign tr_ready    = (state == TRACE_PAY) && load_en && (remaining != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ARB;
      out_valid      <= 1'b0;
      out_word       <= 16'h0000;
      swd_ready      <= 1'b0;
      busy           <= 1'b0;
      seq            <= 6'd0;
      last_grant_swd <= 1'b1;
      flush_cnt      <= '0;
      remaining      <= 4'd0;
      loaded         <= 5'd0;
      swd_lo         <= 16'h0000;
      swd_hi         <= 16'h0000;
    end else begin
      swd_ready <= 1'b0;

      case (state)
        ARB: begin
          if (load_en) begin
            if (enable) begin
              out_word  <= header;
              out_valid <= 1'b1;
              seq       <= seq_next;
              loaded    <= 5'd1;
              busy      <= grant_swd || grant_trace;
              if (grant_swd) begin
                swd_lo         <= swd_data[15:0];
                swd_hi         <= swd_data[31:16];
                swd_ready      <= 1'b1;
                last_grant_swd <= 1'b1;
                remaining      <= 4'd2;
                state          <= SWD_PAY;
              end else if (grant_trace) begin
                last_grant_swd <= 1'b0;
                remaining      <= trace_cnt;
                state          <= TRACE_PAY;
              end else begin
                remaining      <= 4'd0;
                state          <= PAD;
              end
            end else begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end

        SWD_PAY: begin
          if (load_en) begin
            out_valid <= 1'b1;
            out_word  <= (remaining == 4'd2) ? swd_lo : swd_hi;
            loaded    <= loaded + 5'd1;
            remaining <= remaining - 4'd1;
            if (remaining == 4'd1)
              state <= last_loaded ? ARB : PAD;
          end
        end

        TRACE_PAY: begin
          if (load_en) begin
            if (remaining == 4'd0) begin
              out_valid <= 1'b0;
              state     <= PAD;
            end else if (tr_valid) begin
              out_word  <= tr_word;
              out_valid <= 1'b1;
              loaded    <= loaded + 5'd1;
              remaining <= remaining - 4'd1;
              if (last_loaded)
                state <= ARB;
              else if (remaining == 4'd1)
                state <= PAD;
            end else begin
              // FIFO ran dry mid-frame: stall rather than insert filler.
              out_valid <= 1'b0;
            end
          end
        end

        PAD: begin
          if (load_en) begin
            if (loaded >= TOTAL_W) begin
              out_valid <= 1'b0;
              state     <= ARB;
            end else begin
              out_word  <= 16'h0000;
              out_valid <= 1'b1;
              loaded    <= loaded + 5'd1;
              if (last_loaded)
                state <= ARB;
            end
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= ARB;
        end
      endcase

      if ((state == ARB) && load_en && enable && grant_trace)
        flush_cnt <= '0;
      else if (state != TRACE_PAY) begin
        if (tr_level == 5'd0)
          flush_cnt <= '0;
        else if (flush_cnt != FLUSH_MAX)
          flush_cnt <= flush_cnt + FCW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_link_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_link_frame_scheduler: directed frame checks for link_frame_scheduler.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_link_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  width;
  logic        sync;
  logic        tr_valid;
  logic [15:0] tr_word;
  logic [4:0]  tr_level;
  logic        tr_ready;
  logic        swd_valid;
  logic [31:0] swd_data;
  logic        swd_parity;
  logic        swd_ready;
  logic        out_valid;
  logic [15:0] out_word;
  logic        out_ready;
  logic        busy;
  logic [5:0]  seq;

  link_frame_scheduler #(.FRAME_WORDS(8), .FLUSH_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .width(width), .sync(sync),
    .tr_valid(tr_valid), .tr_word(tr_word), .tr_level(tr_level), .tr_ready(tr_ready),
    .swd_valid(swd_valid), .swd_data(swd_data), .swd_parity(swd_parity),
    .swd_ready(swd_ready), .out_valid(out_valid), .out_word(out_word),
    .out_ready(out_ready), .busy(busy), .seq(seq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] rx[$];
  logic [15:0] tq[$];
  int pops, trr, pulses, cyc;
  bit refill, rand_ready, swd_auto;
  logic [15:0] next_tw;

  typedef struct {
    logic [1:0]  width;
    logic        sync;
    int          tr_n;
    logic [15:0] tr_base;
    logic        swd_v;
    logic [31:0] swd_d;
    logic        swd_p;
    int          kind;      // 0 idle, 1 trace, 2 swd
    logic [15:0] exp_hdr;
    int          exp_pops;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_trace();
    tr_valid = (tq.size() != 0);
    tr_word  = (tq.size() != 0) ? tq[0] : 16'h0000;
    tr_level = (tq.size() > 31) ? 5'd31 : 5'(tq.size());
  endtask

  task automatic step();
    bit do_pop, got_pulse;
    @(negedge clk);
    if (out_valid && out_ready) rx.push_back(out_word);
    if (tr_ready) trr++;
    do_pop    = tr_ready && tr_valid;
    got_pulse = swd_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (do_pop) begin
      void'(tq.pop_front());
      pops++;
    end
    if (got_pulse) begin
      pulses++;
      if (swd_auto) begin
        swd_data   = swd_data + 32'd1;
        swd_parity = ^swd_data;
      end else begin
        swd_valid = 1'b0;
      end
    end
    if (refill)
      while (tq.size() < 12) begin
        tq.push_back(next_tw);
        next_tw++;
      end
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    drive_trace();
  endtask

  task automatic collect(input int n, input int budget);
    int b = budget;
    while (rx.size() < n && b > 0) begin
      step();
      b--;
    end
    if (rx.size() < n) chk("collect_timeout", rx.size(), n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b1; width = 2'd0; sync = 1'b0;
    swd_valid = 1'b0; swd_data = 32'h0; swd_parity = 1'b0; out_ready = 1'b1;
    refill = 0; rand_ready = 0; swd_auto = 0;
    tq.delete();
    drive_trace();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx.delete();
    pops = 0; trr = 0; pulses = 0; cyc = 0;
  endtask

  function automatic logic [15:0] exp_payload(input vec_t v, input int i);
    int n = (v.tr_n > 8) ? 8 : v.tr_n;
    if (v.kind == 1) return (i <= n) ? v.tr_base + 16'(i - 1) : 16'h0000;
    if (v.kind == 2) return (i == 1) ? v.swd_d[15:0] : ((i == 2) ? v.swd_d[31:16] : 16'h0000);
    return 16'h0000;
  endfunction

  initial begin
    vec_t vt[6];
    logic [15:0] exp_tw;
    logic [31:0] exp_sd;
    logic [15:0] pad_or;

    vt[0] = '{2'd2, 1'b1, 0,  16'h0000, 1'b0, 32'h0,         1'b0, 0, 16'h2801, 0};
    vt[1] = '{2'd3, 1'b1, 8,  16'h1001, 1'b0, 32'h0,         1'b0, 1, 16'hBC01, 8};
    vt[2] = '{2'd1, 1'b0, 0,  16'h0000, 1'b1, 32'hDEADBEEF,  1'b1, 2, 16'hD141, 0};
    vt[3] = '{2'd2, 1'b1, 0,  16'h0000, 1'b1, 32'h12345678,  1'b0, 2, 16'hE901, 0};
    vt[4] = '{2'd0, 1'b0, 12, 16'h2000, 1'b0, 32'h0,         1'b0, 1, 16'h8401, 8};
    vt[5] = '{2'd2, 1'b0, 8,  16'h3000, 1'b1, 32'hAAAA5555,  1'b1, 1, 16'hA401, 8};

    // Reset values.
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_seq", seq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_swd_ready", swd_ready, 0);
    chk("rst_tr_ready", tr_ready, 0);

    // Table: first frame after reset for each input pattern.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      width = vt[r].width; sync = vt[r].sync;
      for (int k = 0; k < vt[r].tr_n; k++) tq.push_back(vt[r].tr_base + 16'(k));
      swd_valid = vt[r].swd_v; swd_data = vt[r].swd_d; swd_parity = vt[r].swd_p;
      drive_trace();
      collect(9, 200);
      chk($sformatf("vec%0d_hdr", r), rx[0], vt[r].exp_hdr);
      for (int i = 1; i <= 8; i++)
        chk($sformatf("vec%0d_w%0d", r, i), rx[i], exp_payload(vt[r], i));
      chk($sformatf("vec%0d_tr_ready_cycles", r), trr, vt[r].exp_pops);
      chk($sformatf("vec%0d_swd_pulses", r), pulses, (vt[r].kind == 2) ? 1 : 0);
    end

    // Idle stream with seq wrap.
    do_reset();
    collect(65 * 9, 1500);
    pad_or = 16'h0000;
    for (int k = 0; k < 65; k++) begin
      chk($sformatf("idle_hdr%0d", k), rx[k * 9], 16'((k + 1) % 64));
      for (int i = 1; i <= 8; i++) pad_or = pad_or | rx[k * 9 + i];
    end
    chk("idle_pads_zero", pad_or, 0);

    // Partial backlog is flushed only after FLUSH_CYCLES.
    do_reset();
    for (int k = 0; k < 3; k++) tq.push_back(16'h5001 + 16'(k));
    drive_trace();
    collect(27, 300);
    chk("flush_idle1", rx[0], 16'h0001);
    chk("flush_idle2", rx[9], 16'h0002);
    chk("flush_hdr", rx[18], 16'h8183);
    for (int i = 1; i <= 8; i++)
      chk($sformatf("flush_w%0d", i), rx[18 + i], (i <= 3) ? 16'h5000 + 16'(i) : 16'h0000);
    chk("flush_pops", pops, 3);

    // Enable low holds ARB.
    do_reset();
    enable = 1'b0;
    for (int k = 0; k < 8; k++) tq.push_back(16'h6000 + 16'(k));
    drive_trace();
    repeat (20) step();
    chk("en_low_words", rx.size(), 0);
    chk("en_low_pops", pops, 0);
    enable = 1'b1;
    collect(9, 100);
    chk("en_hdr", rx[0], 16'h8401);
    chk("en_first", rx[1], 16'h6000);
    chk("en_last", rx[8], 16'h6007);

    // Contention with random backpressure: strict alternation, nothing lost.
    do_reset();
    refill = 1; next_tw = 16'h4000;
    swd_auto = 1; swd_valid = 1'b1; swd_data = 32'hC0DE0000; swd_parity = ^swd_data;
    rand_ready = 1;
    while (tq.size() < 12) begin
      tq.push_back(next_tw);
      next_tw++;
    end
    drive_trace();
    collect(54, 3000);
    rand_ready = 0; out_ready = 1'b1;
    exp_tw = 16'h4000;
    exp_sd = 32'hC0DE0000;
    for (int f = 0; f < 6; f++) begin
      if (f % 2 == 0) begin
        chk($sformatf("alt%0d_trace_hdr", f), rx[f * 9], 16'h8400 | 16'(f + 1));
        for (int i = 1; i <= 8; i++) begin
          chk($sformatf("alt%0d_trace_w%0d", f, i), rx[f * 9 + i], exp_tw);
          exp_tw++;
        end
      end else begin
        chk($sformatf("alt%0d_swd_hdr", f), rx[f * 9],
            16'hC100 | (16'(^exp_sd) << 6) | 16'(f + 1));
        chk($sformatf("alt%0d_swd_lo", f), rx[f * 9 + 1], exp_sd[15:0]);
        chk($sformatf("alt%0d_swd_hi", f), rx[f * 9 + 2], exp_sd[31:16]);
        for (int i = 3; i <= 8; i++)
          chk($sformatf("alt%0d_swd_pad%0d", f, i), rx[f * 9 + i], 16'h0000);
        exp_sd++;
      end
    end

    // Reset asserted during the third payload word of a trace frame.
    do_reset();
    width = 2'd3; sync = 1'b1;
    for (int k = 0; k < 8; k++) tq.push_back(16'h1001 + 16'(k));
    drive_trace();
    collect(3, 100);
    chk("midrst_third_word", out_word, 16'h1003);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_seq", seq, 0);
    chk("midrst_busy", busy, 0);
    do_reset();
    width = 2'd3; sync = 1'b1;
    for (int k = 0; k < 8; k++) tq.push_back(16'h1001 + 16'(k));
    drive_trace();
    collect(2, 100);
    chk("midrst_new_hdr", rx[0], 16'hBC01);
    chk("midrst_new_w1", rx[1], 16'h1001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
